// File: rtl/fifo_sync.sv
// fifo_sync: small synchronous first-word-fall-through FIFO.
// The oldest stored word is always presented on data_read. Status flags are
// decoded from the registered occupancy count only, so they never depend
// combinationally on write or next_read.
module fifo_sync #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  // Last legal pointer value; the pointers wrap with an explicit compare so
  // that depths which are not a power of two work as well.
  localparam logic [LOG_NUM_SLOTS-1:0] LAST_PTR     = LOG_NUM_SLOTS'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS:0]   FULL_COUNT   = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   ALMOST_COUNT = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS:0]   ZERO_COUNT   = (LOG_NUM_SLOTS + 1)'(0);
  localparam logic [LOG_NUM_SLOTS:0]   ONE_COUNT    = (LOG_NUM_SLOTS + 1)'(1);

  // Advance a pointer by one slot, returning to zero after the last slot.
  function automatic logic [LOG_NUM_SLOTS-1:0] next_ptr(input logic [LOG_NUM_SLOTS-1:0] ptr);
    logic [LOG_NUM_SLOTS-1:0] result;
    if (ptr == LAST_PTR) begin
      result = {LOG_NUM_SLOTS{1'b0}};
    end else begin
      result = ptr + {{(LOG_NUM_SLOTS-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // Storage has no reset so it can map onto distributed RAM or plain flops.
  logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];

  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS:0]   count;

  logic [LOG_NUM_SLOTS-1:0] wr_ptr_next;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_next;
  logic [LOG_NUM_SLOTS:0]   count_next;
  logic                     wr_en;
  logic                     rd_en;

  // Flags come straight from the registered count.
  assign full        = (count == FULL_COUNT);
  assign almost_full = (count >= ALMOST_COUNT);
  assign empty       = (count == ZERO_COUNT);

  // Head of the queue falls through without waiting for a read request.
  assign data_read   = mem[rd_ptr];

  // Acceptance and next-state decode for the pointers and occupancy count.
  always_comb begin
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;

    // A write while full is dropped even if a read pops in the same cycle.
    if (write && !full) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end

    // A read while empty is ignored, even if a write lands in the same cycle.
    if (next_read && !empty) begin
      rd_en = 1'b1;
    end else begin
      rd_en = 1'b0;
    end

    if (wr_en) begin
      wr_ptr_next = next_ptr(wr_ptr);
    end else begin
      wr_ptr_next = wr_ptr;
    end

    if (rd_en) begin
      rd_ptr_next = next_ptr(rd_ptr);
    end else begin
      rd_ptr_next = rd_ptr;
    end

    case ({wr_en, rd_en})
      2'b10:   count_next = count + ONE_COUNT;
      2'b01:   count_next = count - ONE_COUNT;
      2'b11:   count_next = count;
      2'b00:   count_next = count;
      default: count_next = count;
    endcase
  end

  // Pointer and count registers; reset discards the contents immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {LOG_NUM_SLOTS{1'b0}};
      rd_ptr <= {LOG_NUM_SLOTS{1'b0}};
      count  <= ZERO_COUNT;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Storage write port: an accepted word lands in the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_write;
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed bench for fifo_sync with a queue scoreboard.
// Expected words are pushed when an accepted write is driven and popped when
// the bench pops the head; flags are checked against a bench occupancy count.
module tb_fifo_sync;

  localparam int NS = 4;
  localparam int LG = 2;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_write;
  logic          write;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] data_read;
  logic          next_read;
  logic          empty;

  int            checks = 0;
  int            errors = 0;
  int            mcount = 0;
  logic [DW-1:0] sb [$];

  fifo_sync #(
    .NUM_SLOTS    (NS),
    .LOG_NUM_SLOTS(LG),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_write (data_write),
    .write      (write),
    .full       (full),
    .almost_full(almost_full),
    .data_read  (data_read),
    .next_read  (next_read),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check1({tag, " empty"}, empty, mcount == 0);
    check1({tag, " full"}, full, mcount == NS);
    check1({tag, " almost_full"}, almost_full, mcount >= NS - 1);
    if (mcount != 0) begin
      check({tag, " head"}, data_read, sb[0]);
    end
  endtask

  // One clock cycle of stimulus; inputs are driven 1 time unit after an edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    logic wacc;
    logic racc;
    write      = w;
    data_write = d;
    next_read  = r;
    wacc = w && (mcount != NS);
    racc = r && (mcount != 0);
    if (racc) begin
      check("pop data", data_read, sb[0]);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (wacc) begin
      sb.push_back(d);
    end
    mcount = mcount + (wacc ? 1 : 0) - (racc ? 1 : 0);
    write     = 1'b0;
    next_read = 1'b0;
    check_flags("cycle");
  endtask

  // Assert reset in the middle of a cycle and check flags before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check1({tag, " rst empty"}, empty, 1'b1);
    check1({tag, " rst full"}, full, 1'b0);
    check1({tag, " rst almost_full"}, almost_full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mcount = 0;
  endtask

  initial begin
    rst        = 1'b1;
    write      = 1'b0;
    next_read  = 1'b0;
    data_write = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle
    async_reset("reset idle");
    cycle(1'b0, 64'h0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0);

    // Fill and drain
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 64'hA0 + 64'(i), 1'b0);
      if (i == 2) begin
        check1("fill3 almost_full", almost_full, 1'b1);
        check1("fill3 full", full, 1'b0);
      end
      if (i == 3) begin
        check1("fill4 full", full, 1'b1);
      end
    end
    cycle(1'b1, 64'hFF, 1'b0);
    check1("dropped write full", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain order", data_read, 64'hA0 + 64'(i));
      cycle(1'b0, 64'h0, 1'b1);
    end
    check1("drained empty", empty, 1'b1);

    // FWFT latency
    cycle(1'b1, 64'h55, 1'b0);
    check1("fwft empty", empty, 1'b0);
    check("fwft data", data_read, 64'h55);
    cycle(1'b0, 64'h0, 1'b1);
    check1("fwft pop empty", empty, 1'b1);

    // Simultaneous read/write at occupancy 2
    cycle(1'b1, 64'h01, 1'b0);
    cycle(1'b1, 64'h02, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 64'h10 + 64'(i), 1'b1);
      check1("steady full", full, 1'b0);
      check1("steady almost_full", almost_full, 1'b0);
      check1("steady empty", empty, 1'b0);
    end
    check("steady head", data_read, 64'h14);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);

    // Full plus write and read
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 64'hB0 + 64'(i), 1'b0);
    end
    cycle(1'b1, 64'hEE, 1'b1);
    check1("full rw full", full, 1'b0);
    check1("full rw almost_full", almost_full, 1'b1);
    check("full rw head", data_read, 64'hB1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'h0, 1'b1);
    end
    check1("full rw drained", empty, 1'b1);

    // Empty plus write and read
    cycle(1'b1, 64'h66, 1'b1);
    check1("empty rw empty", empty, 1'b0);
    check("empty rw data", data_read, 64'h66);
    cycle(1'b0, 64'h0, 1'b1);

    // Wrap-around: ten write/pop rounds move both pointers around twice
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 64'h300 + 64'(i), 1'b0);
      check("wrap head", data_read, 64'h300 + 64'(i));
      cycle(1'b0, 64'h0, 1'b1);
    end

    // Read while empty must not move anything
    cycle(1'b0, 64'h0, 1'b1);
    check1("illegal read empty", empty, 1'b1);
    cycle(1'b1, 64'h88, 1'b0);
    check("after illegal read", data_read, 64'h88);
    cycle(1'b0, 64'h0, 1'b1);

    // Reset with three words stored
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'hC0 + 64'(i), 1'b0);
    end
    check1("pre-reset almost_full", almost_full, 1'b1);
    async_reset("reset mid");
    check1("post-reset empty", empty, 1'b1);
    cycle(1'b1, 64'h77, 1'b0);
    check("post-reset first word", data_read, 64'h77);
    cycle(1'b0, 64'h0, 1'b1);
    check1("final empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
